mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle control FSM that replaces the single-cycle opcode decoder in the MIPS core. It sequences each instruction over 3–5 states and drives a shared-memory, single-ALU datapath. It adds memory-ready wait states, an external hold, a bounded wait timeout and illegal-opcode reporting. It has the same opcode set as the single-cycle unit: R-type, ADDI, ORI, ANDI, BEQ, BNE, LUI, LW, SW and J.

## Interface
- ALUOP_WIDTH, 3: width of ALUOp, must be ≥3. Codes are in bits [2:0]; upper bits are driven 0.
- MAX_WAIT, 15: maximum consecutive cycles spent waiting on MemReady before a timeout. 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP  in  6  opcode from the instruction register. It is sampled only in DECODE.
- Zero  in  1  ALU zero flag. It is used only in BRANCH.
- MemReady  in  1  memory completes the current access this cycle.
- Hold  in  1  freeze request from the debug or hazard logic.
- PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  standard multicycle datapath controls.
- ALUSrcB  out  2  source select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- PCSource  out  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_WIDTH  ALU operation code: 111 R-type (funct), 100 add, 101 or, 110 and, 011 lui, 001 sub.
- IllegalOp  out  1  one-cycle pulse when an unknown opcode is decoded.
- Timeout  out  1  one-cycle pulse when the memory wait is aborted.
- State  out  4  current state encoding, for debug.

## Operation
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, I_EXEC=8, ALU_WB=9, BRANCH=10, JUMP=11.
- Outputs are Moore outputs of State. The exceptions are the FETCH strobes, which are gated by MemReady, and the BRANCH PCWrite, which is gated by Zero. Any output not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Next state is FETCH.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Moves to DECODE on MemReady, otherwise waits.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=add.
  - Latches the instruction class, the I-type ALUOp and the BEQ/BNE flag from OP.
  - Next state by opcode:
    - R-type → R_EXEC.
    - ADDI/ORI/ANDI/LUI → I_EXEC.
    - LW/SW → MEM_ADDR.
    - BEQ/BNE → BRANCH.
    - J → JUMP.
    - Any other opcode → FETCH, with IllegalOp=1 for that cycle.
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=add.
  - Moves to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ:
  - Drives MemRead=1, IorD=1.
  - Moves to MEM_WB on MemReady, otherwise waits.
- MEM_WB:
  - Drives RegDst=0, MemtoReg=1, RegWrite=1.
  - Next state is FETCH.
- MEM_WRITE:
  - Drives MemWrite=1, IorD=1.
  - Moves to FETCH on MemReady, otherwise waits.
- R_EXEC:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=111.
  - Next state is ALU_WB.
- I_EXEC:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=latched code (ADDI 100, ORI 101, ANDI 110, LUI 011).
  - Next state is ALU_WB.
- ALU_WB:
  - Drives RegWrite=1, MemtoReg=0, RegDst=1 for R-type and 0 for I-type.
  - Next state is FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
  - PCWrite = Zero for BEQ, ~Zero for BNE.
  - Next state is FETCH.
- JUMP:
  - Drives PCSource=10, PCWrite=1.
  - Next state is FETCH.
- Hold=1:
  - State, the latched decode fields and the wait counter are held.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. MemRead is forced to 0. The mux selects keep their state values.
  - Hold takes priority over MemReady, the timeout and IllegalOp. IllegalOp is suppressed and re-evaluated once Hold drops.
- Wait counter:
  - Counts the cycles spent in FETCH, MEM_READ or MEM_WRITE with MemReady=0 and Hold=0. It clears on leaving the state and on MemReady.
  - When the counter equals MAX_WAIT (MAX_WAIT≠0) and MemReady=0, Timeout pulses for one cycle and the next state is IDLE. Write strobes are 0 that cycle.
  - Counter width is clog2(MAX_WAIT+1), minimum 1. The counter saturates and never wraps.

## Timing
- Reset low, asynchronously: State=IDLE, latched fields=0, counter=0. All outputs are 0 throughout reset.
- First FETCH occurs one cycle after reset deasserts.
- Latency with MemReady tied high and no Hold:
  - J and BEQ/BNE: 3 cycles.
  - R-type, I-type ALU and SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle adds one cycle to this latency.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe is asserted after the falling edge of reset.
- Timeout fires on the (MAX_WAIT+1)-th consecutive not-ready cycle.

## Test plan
- Reset, then ADDI (OP=08) with MemReady=1:
  - State sequence 0,1,2,8,9,1.
  - ALUOp=100 in state 8; RegWrite=1 and RegDst=0 only in state 9.
- LW (OP=23) with MemReady low for 2 cycles in MEM_READ:
  - Sequence 1,2,3,4,4,4,5,1.
  - MemtoReg=1 and RegWrite=1 exactly once.
- BEQ (OP=04) with Zero=1 → PCWrite=1 and PCSource=01 in BRANCH.
- BNE (OP=05) with Zero=1 → PCWrite=0 in BRANCH.
- OP=3F:
  - IllegalOp pulses in DECODE and the next state is FETCH.
  - No RegWrite or MemWrite is asserted.
- SW with MAX_WAIT=15 and MemReady held 0:
  - Timeout pulses on the 16th wait cycle, then State=IDLE and MemWrite=0.
- Hold asserted in MEM_WRITE for 3 cycles with MemReady=1:
  - State stays 6 and MemWrite=0.
  - After Hold drops, MemWrite=1 and the FSM proceeds to FETCH.
- Reset pulsed low during R_EXEC → all outputs 0 immediately, and State=IDLE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multicycle control FSM for a shared-memory, single-ALU MIPS datapath.
//   Each instruction is sequenced over 3-5 states. Memory accesses wait on
//   MemReady, and a bounded wait counter aborts a stalled access back to IDLE.
//   Hold freezes the sequencer and suppresses every strobe. Unknown opcodes
//   are reported with a one-cycle IllegalOp pulse.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   OP[5:0]    in   opcode from the instruction register, sampled in DECODE
//   Zero       in   ALU zero flag, used in BRANCH
//   MemReady   in   memory completes the current access this cycle
//   Hold       in   freeze request from debug / hazard logic
//   PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA    out  datapath controls
//   ALUSrcB    out  00 B, 01 const 4, 10 sign-ext imm, 11 imm << 2
//   PCSource   out  00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp      out  111 funct, 100 add, 101 or, 110 and, 011 lui, 001 sub
//   IllegalOp  out  pulse on an unknown opcode in DECODE
//   Timeout    out  pulse when a memory wait is aborted
//   State[3:0] out  current state encoding
module mips_multicycle_control #(
    parameter int ALUOP_WIDTH = 3,
    parameter int MAX_WAIT    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   Zero,
    input  logic                   MemReady,
    input  logic                   Hold,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   IRWrite,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   IllegalOp,
    output logic                   Timeout,
    output logic [3:0]             State
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Instruction class captured in DECODE; later states only look at this.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4,
        CLS_BR   = 3'd5,
        CLS_J    = 3'd6
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    localparam int             CW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic           TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_WAIT);
    localparam logic [CW-1:0]  CNT_SAT    = {CW{1'b1}};
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO   = {CW{1'b0}};

    state_t        state_q, state_d;
    cls_t          cls_q, cls_d;
    logic [2:0]    ialu_q, ialu_d;
    logic          bne_q, bne_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]    alu_op_s;
    logic          wait_state_s;

    // State register, latched decode fields and memory wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_NONE;
            ialu_q  <= 3'b000;
            bne_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ialu_q  <= ialu_d;
            bne_q   <= bne_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, decode capture, wait counter and control outputs.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        ialu_d       = ialu_q;
        bne_d        = bne_q;
        cnt_d        = cnt_q;
        wait_state_s = 1'b0;
        alu_op_s     = 3'b000;
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        IllegalOp    = 1'b0;
        Timeout      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead      = 1'b1;
                ALUSrcB      = 2'b01;
                alu_op_s     = ALU_ADD;
                // IR and PC+4 are only committed once the fetch data is there.
                IRWrite      = MemReady;
                PCWrite      = MemReady;
                wait_state_s = 1'b1;
                if (MemReady) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is computed speculatively here.
                ALUSrcB  = 2'b11;
                alu_op_s = ALU_ADD;
                case (OP)
                    OP_RTYPE: begin cls_d = CLS_R;  state_d = S_R_EXEC; end
                    OP_ADDI:  begin cls_d = CLS_I;  ialu_d = ALU_ADD; state_d = S_I_EXEC; end
                    OP_ORI:   begin cls_d = CLS_I;  ialu_d = ALU_OR;  state_d = S_I_EXEC; end
                    OP_ANDI:  begin cls_d = CLS_I;  ialu_d = ALU_AND; state_d = S_I_EXEC; end
                    OP_LUI:   begin cls_d = CLS_I;  ialu_d = ALU_LUI; state_d = S_I_EXEC; end
                    OP_LW:    begin cls_d = CLS_LW; state_d = S_MEM_ADDR; end
                    OP_SW:    begin cls_d = CLS_SW; state_d = S_MEM_ADDR; end
                    OP_BEQ:   begin cls_d = CLS_BR; bne_d = 1'b0; state_d = S_BRANCH; end
                    OP_BNE:   begin cls_d = CLS_BR; bne_d = 1'b1; state_d = S_BRANCH; end
                    OP_J:     begin cls_d = CLS_J;  state_d = S_JUMP; end
                    default: begin
                        cls_d     = CLS_NONE;
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_op_s = ALU_ADD;
                if (cls_q == CLS_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                MemRead      = 1'b1;
                IorD         = 1'b1;
                wait_state_s = 1'b1;
                if (MemReady) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite     = 1'b1;
                IorD         = 1'b1;
                wait_state_s = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_R_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b00;
                alu_op_s = ALU_FUNCT;
                state_d  = S_ALU_WB;
            end
            S_I_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_op_s = ialu_q;
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                if (cls_q == CLS_R) begin
                    RegDst = 1'b1;
                end else begin
                    RegDst = 1'b0;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b00;
                alu_op_s = ALU_SUB;
                PCSource = 2'b01;
                if (bne_q) begin
                    PCWrite = ~Zero;
                end else begin
                    PCWrite = Zero;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Wait counter: counts consecutive not-ready cycles in a memory state.
        if (wait_state_s) begin
            if (MemReady) begin
                cnt_d = CNT_ZERO;
            end else if (TIMEOUT_EN && (cnt_q == MAX_CNT)) begin
                // Abort the access; nothing may be committed on this cycle.
                Timeout  = 1'b1;
                state_d  = S_IDLE;
                cnt_d    = CNT_ZERO;
                PCWrite  = 1'b0;
                IRWrite  = 1'b0;
                RegWrite = 1'b0;
                MemWrite = 1'b0;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end

        // Hold wins over everything: freeze state and kill every strobe,
        // while the mux selects keep showing the current state's values.
        if (Hold) begin
            state_d   = state_q;
            cls_d     = cls_q;
            ialu_d    = ialu_q;
            bne_d     = bne_q;
            cnt_d     = cnt_q;
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            MemRead   = 1'b0;
            IllegalOp = 1'b0;
            Timeout   = 1'b0;
        end else begin
            state_d = state_d;
        end

        ALUOp      = {ALUOP_WIDTH{1'b0}};
        ALUOp[2:0] = alu_op_s;
        State      = state_q;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
//   Directed test of the multicycle control FSM. Each stimulus cycle pushes
//   a hand-written expected output vector into a scoreboard queue; a monitor
//   on the falling clock edge pops and compares it against the DUT outputs.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OP = 6'h00;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       Hold = 1'b0;

    logic       PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg;
    logic       RegDst, RegWrite, ALUSrcA, IllegalOp, Timeout;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    mips_multicycle_control #(.ALUOP_WIDTH(3), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady), .Hold(Hold),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .IllegalOp(IllegalOp), .Timeout(Timeout), .State(State)
    );

    always #5 clk = ~clk;

    // strb = {PCWrite,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA}
    typedef struct packed {
        logic [8:0] strb;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
        logic       tmo;
        logic [3:0] st;
    } out_t;

    typedef struct {
        int   id;
        out_t exp;
    } item_t;

    localparam out_t E_IDLE    = {9'b000000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd0};
    localparam out_t E_FETCH_R = {9'b101100000, 2'b01, 2'b00, 3'b100, 1'b0, 1'b0, 4'd1};
    localparam out_t E_FETCH_W = {9'b000100000, 2'b01, 2'b00, 3'b100, 1'b0, 1'b0, 4'd1};
    localparam out_t E_FETCH_H = {9'b000000000, 2'b01, 2'b00, 3'b100, 1'b0, 1'b0, 4'd1};
    localparam out_t E_DEC     = {9'b000000000, 2'b11, 2'b00, 3'b100, 1'b0, 1'b0, 4'd2};
    localparam out_t E_DEC_ILL = {9'b000000000, 2'b11, 2'b00, 3'b100, 1'b1, 1'b0, 4'd2};
    localparam out_t E_MADDR   = {9'b000000001, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0, 4'd3};
    localparam out_t E_MRD     = {9'b010100000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd4};
    localparam out_t E_MWB     = {9'b000001010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd5};
    localparam out_t E_MWR     = {9'b010010000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd6};
    localparam out_t E_MWR_H   = {9'b010000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd6};
    localparam out_t E_MWR_TMO = {9'b010000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 4'd6};
    localparam out_t E_REXEC   = {9'b000000001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0, 4'd7};
    localparam out_t E_IADD    = {9'b000000001, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0, 4'd8};
    localparam out_t E_IOR     = {9'b000000001, 2'b10, 2'b00, 3'b101, 1'b0, 1'b0, 4'd8};
    localparam out_t E_ILUI    = {9'b000000001, 2'b10, 2'b00, 3'b011, 1'b0, 1'b0, 4'd8};
    localparam out_t E_WB_R    = {9'b000000110, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd9};
    localparam out_t E_WB_I    = {9'b000000010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 4'd9};
    localparam out_t E_BR_T    = {9'b100000001, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 4'd10};
    localparam out_t E_BR_N    = {9'b000000001, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 4'd10};
    localparam out_t E_JMP     = {9'b100000000, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0, 4'd11};

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BAD  = 6'h3F;

    item_t sb_q[$];
    item_t it_v;
    int    n_chk  = 0;
    int    n_pass = 0;
    int    step_id = 0;
    out_t  act_s;

    always_comb act_s = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
                         RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp,
                         Timeout, State};

    task automatic check(input int id, input out_t exp);
        n_chk = n_chk + 1;
        if (act_s === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL step%0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                     id, act_s.st, act_s, exp.st, exp);
        end
    endtask

    // One clock cycle of stimulus: inputs change just after the rising edge,
    // and the expected outputs of the state entered at that edge are queued.
    task automatic cyc(input logic rst_v, input logic [5:0] op_v, input logic zero_v,
                       input logic rdy_v, input logic hold_v, input out_t exp);
        item_t it;
        @(posedge clk);
        #1;
        reset    = rst_v;
        OP       = op_v;
        Zero     = zero_v;
        MemReady = rdy_v;
        Hold     = hold_v;
        step_id  = step_id + 1;
        it.id    = step_id;
        it.exp   = exp;
        sb_q.push_back(it);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            it_v = sb_q.pop_front();
            check(it_v.id, it_v.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    initial begin
        // Reset held low with MemReady high: everything stays 0.
        cyc(1'b0, OP_ADDI, 1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b0, OP_ADDI, 1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, 1'b0, E_IDLE);
        // ADDI: 1,2,8,9
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, 1'b0, E_IADD);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, 1'b0, E_WB_I);
        // LW with two not-ready cycles in MEM_READ: 1,2,3,4,4,4,5
        cyc(1'b1, OP_LW, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_LW, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_LW, 1'b0, 1'b1, 1'b0, E_MADDR);
        cyc(1'b1, OP_LW, 1'b0, 1'b0, 1'b0, E_MRD);
        cyc(1'b1, OP_LW, 1'b0, 1'b0, 1'b0, E_MRD);
        cyc(1'b1, OP_LW, 1'b0, 1'b1, 1'b0, E_MRD);
        cyc(1'b1, OP_LW, 1'b0, 1'b1, 1'b0, E_MWB);
        // BEQ taken
        cyc(1'b1, OP_BEQ, 1'b1, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_BEQ, 1'b1, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_BEQ, 1'b1, 1'b1, 1'b0, E_BR_T);
        // BNE with Zero=1 is not taken
        cyc(1'b1, OP_BNE, 1'b1, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_BNE, 1'b1, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_BNE, 1'b1, 1'b1, 1'b0, E_BR_N);
        // J
        cyc(1'b1, OP_J, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_J, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_J, 1'b0, 1'b1, 1'b0, E_JMP);
        // ORI and LUI select their latched ALU codes
        cyc(1'b1, OP_ORI, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_ORI, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_ORI, 1'b0, 1'b1, 1'b0, E_IOR);
        cyc(1'b1, OP_ORI, 1'b0, 1'b1, 1'b0, E_WB_I);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, E_ILUI);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, E_WB_I);
        // Illegal opcode: pulse in DECODE, straight back to FETCH
        cyc(1'b1, OP_BAD, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_BAD, 1'b0, 1'b1, 1'b0, E_DEC_ILL);
        // SW with memory never ready: 15 wait cycles, timeout on the 16th
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0, E_MADDR);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0, E_MWR);
        end
        cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0, E_MWR_TMO);
        cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0, E_IDLE);
        // FETCH: not ready, then held while ready, then ready
        cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0, E_FETCH_W);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b1, E_FETCH_H);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        // SW held three cycles in MEM_WRITE with memory ready
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_MADDR);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b1, E_MWR_H);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b1, E_MWR_H);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b1, E_MWR_H);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, 1'b0, E_MWR);
        // Illegal opcode under Hold is suppressed, then reported
        cyc(1'b1, OP_BAD, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_BAD, 1'b0, 1'b1, 1'b1, E_DEC);
        cyc(1'b1, OP_BAD, 1'b0, 1'b1, 1'b0, E_DEC_ILL);
        // R-type to completion
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_REXEC);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_WB_R);
        // R-type interrupted by reset in R_EXEC
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_DEC);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_REXEC);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check(999, E_IDLE);
        cyc(1'b0, OP_R, 1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b1, OP_R, 1'b0, 1'b1, 1'b0, E_FETCH_R);
        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk = n_chk + 1;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
